ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Consumes the byte stream from `Ps2Interface` (`rx_data`, `read_data`) and decodes PS/2 Set-2 make/break sequences.
- Produces held-level direction keys and one-cycle key events for the game logic.
- Game logic turns these into the player position that drives the VGA display stage.
- Sits directly downstream of `Ps2Interface`, in the `clk_100mHz` domain.

Parameters:
- TIMEOUT_CYCLES, 500000: clock cycles a pending prefix (E0/F0) may wait for its next byte before being discarded (5 ms at 100 MHz).
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter.

Ports:
- clk_100mHz  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- rx_data  in  8  received scan-code byte from `Ps2Interface`
- read_data  in  1  byte-valid strobe from `Ps2Interface`
- key_up  out  1  up direction held
- key_down  out  1  down direction held
- key_left  out  1  left direction held
- key_right  out  1  right direction held
- key_event  out  1  one-cycle pulse when any held bit changes
- key_id  out  2  key for the event: 0 up, 1 down, 2 left, 3 right
- key_pressed  out  1  1 = press, 0 = release; valid with key_event

Behaviour:
- Reset: all outputs 0, FSM = IDLE, timeout counter = 0, read_data history register = 0.
- Strobe: a byte is accepted on the cycle where read_data = 1 and its registered previous value = 0. A held-high strobe is accepted once. rx_data is sampled on that cycle.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
- Transitions on an accepted byte:
  - E0 from IDLE, GOT_E0 or GOT_F0 -> GOT_E0. E0 from GOT_E0F0 -> GOT_E0.
  - F0 from IDLE -> GOT_F0; from GOT_E0 -> GOT_E0F0. F0 in GOT_F0 or GOT_E0F0 -> unchanged.
  - Any other byte: decode it, then -> IDLE.
- Decode:
  - In GOT_E0, make: 75 up, 72 down, 6B left, 74 right.
  - In GOT_E0F0, break of the same codes.
  - Codes in IDLE/GOT_F0 are non-extended: no arrow action unless WASD_EN is defined.
  - Unrecognised codes: no action, -> IDLE.
- Special bytes, in any state:
  - AA (BAT) and FF/00 (error/overrun): clear all held keys silently (no events), -> IDLE.
  - FA (ACK) and FE (resend): ignored, state unchanged.
- Held bits:
  - Make sets the key, break clears it.
  - Typematic repeats of a held key change nothing and produce no event.
  - Break of a key not held: no action.
- Events:
  - Generated only when a held bit changes.
  - key_event, key_id and key_pressed are registered and asserted the cycle after the accepted strobe (latency 1). The held output updates on that same cycle.
  - At most one key changes per byte, so no event arbitration is needed.
- Timeout:
  - The counter runs while state != IDLE and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 with no strobe, FSM -> IDLE and the counter clears.
  - A strobe on the expiry cycle wins: the byte is processed in the current state.
- Reset mid-sequence: immediate return to reset values. A following orphan break byte decodes as non-extended (no arrow effect).
- Opposing directions (up+down) may both be held; resolving them is the consumer's job.

Optional Feature:
- Macro: PS2_KEY_DECODER_WASD_EN.
- When defined:
  - Non-extended make/break in IDLE/GOT_F0 of 1D (W) up, 1B (S) down, 1C (A) left, 23 (D) right also drive directions.
  - Arrow and WASD held state are tracked separately; each output is the OR of the two.
  - Events fire only on a change of the ORed output. Example: pressing W while Up is held gives no event; releasing Up while W is still held gives no event.
- When undefined: those codes are unrecognised; no extra registers are generated.

Decomposition:
- Shared package `ps2_key_pkg`:
  - Scan-code constants: E0, F0, AA, FA, FE, FF, 00, arrow and WASD codes.
  - FSM state encoding.
  - key_id constants: KEY_UP=0, KEY_DOWN=1, KEY_LEFT=2, KEY_RIGHT=3.
- One natural sub-module: `ps2_strobe_edge` (read_data history register plus rising-edge pulse), reusable by other `Ps2Interface` consumers.

Test Plan:
- Sequence E0,75: key_up=1, key_event pulse with key_id=0 and key_pressed=1, one cycle after the second strobe. Then E0,F0,75: key_up=0, event key_id=0, key_pressed=0.
- E0,6B followed by E0,6B repeated x3 (typematic): exactly one event; key_left stays 1.
- E0,74 then byte AA: key_right clears to 0 with no event; state IDLE. A following 75 alone has no effect.
- E0, then no strobe for TIMEOUT_CYCLES (test value 16): FSM back to IDLE. A subsequent 72 alone does not set key_down. Same scenario with 72 arriving on cycle 15: key_down=1.
- read_data held high 10 cycles with rx_data=E0, then a single-cycle 72 strobe: processed as E0 once then 72, so key_down=1.
- With PS2_KEY_DECODER_WASD_EN: 1D sets key_up (event). E0,75 gives no event. F0,1D gives no event and key_up stays 1. E0,F0,75 clears key_up with an event.
- Assert reset (0) mid-sequence after E0: all outputs 0 asynchronously.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared PS/2 Set-2 scan-code constants, decoder state encoding and key lookup helpers.
// Used by ps2_key_decoder and any other Ps2Interface consumer.
package ps2_key_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR    = 8'hFF;
  localparam logic [7:0] SC_OVR    = 8'h00;

  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;

  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_D = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } dec_state_e;

  typedef logic [1:0] key_id_t;

  localparam key_id_t KEY_UP    = 2'd0;
  localparam key_id_t KEY_DOWN  = 2'd1;
  localparam key_id_t KEY_LEFT  = 2'd2;
  localparam key_id_t KEY_RIGHT = 2'd3;

  typedef struct packed {
    logic    hit;
    key_id_t id;
  } key_hit_t;

  function automatic key_hit_t lookup_arrow(input logic [7:0] code);
    key_hit_t r;
    r = '0;
    case (code)
      SC_ARROW_UP:    r = '{hit: 1'b1, id: KEY_UP};
      SC_ARROW_DOWN:  r = '{hit: 1'b1, id: KEY_DOWN};
      SC_ARROW_LEFT:  r = '{hit: 1'b1, id: KEY_LEFT};
      SC_ARROW_RIGHT: r = '{hit: 1'b1, id: KEY_RIGHT};
      default:        r = '0;
    endcase
    return r;
  endfunction

  function automatic key_hit_t lookup_wasd(input logic [7:0] code);
    key_hit_t r;
    r = '0;
    case (code)
      SC_W:    r = '{hit: 1'b1, id: KEY_UP};
      SC_S:    r = '{hit: 1'b1, id: KEY_DOWN};
      SC_A:    r = '{hit: 1'b1, id: KEY_LEFT};
      SC_D:    r = '{hit: 1'b1, id: KEY_RIGHT};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_strobe_edge.sv
// Registers the Ps2Interface read_data strobe and emits a one-cycle pulse on its rising edge,
// so a strobe held high for several cycles delivers its byte only once.
module ps2_strobe_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic read_data,
  output logic strobe
);

  logic rd_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_hist <= 1'b0;
    else        rd_hist <= read_data;
  end

  assign strobe = read_data & ~rd_hist;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 make/break decoder producing held arrow-direction levels and one-cycle key events.
// Optional PS2_KEY_DECODER_WASD_EN also maps non-extended W/A/S/D onto the same directions.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk_100mHz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       read_data,
  output logic       key_up,
  output logic       key_down,
  output logic       key_left,
  output logic       key_right,
  output logic       key_event,
  output logic [1:0] key_id,
  output logic       key_pressed
);

  logic strobe_p0;

  ps2_strobe_edge u_strobe_edge (
    .clk       (clk_100mHz),
    .rst_n     (reset),
    .read_data (read_data),
    .strobe    (strobe_p0)
  );

  dec_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       arrow_q, arrow_d;
  logic [3:0]       held_cur, held_d, chg;
  logic             silent;
  key_hit_t         arw;
  logic             evt_d, evt_p1;
  key_id_t          id_d, id_p1;
  logic             pressed_d, pressed_p1;
`ifdef PS2_KEY_DECODER_WASD_EN
  logic [3:0]       wasd_q, wasd_d;
  key_hit_t         wsd;
`endif

`ifdef PS2_KEY_DECODER_WASD_EN
  assign held_cur = arrow_q | wasd_q;
`else
  assign held_cur = arrow_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arrow_d   = arrow_q;
    silent    = 1'b0;
    arw       = lookup_arrow(rx_data);
`ifdef PS2_KEY_DECODER_WASD_EN
    wasd_d    = wasd_q;
    wsd       = lookup_wasd(rx_data);
`endif

    if (strobe_p0) begin
      // An accepted byte always restarts the prefix timeout, even on expiry.
      cnt_d = '0;
      case (rx_data)
        SC_E0: state_d = ST_GOT_E0;
        SC_F0: begin
          if (state_q == ST_IDLE)        state_d = ST_GOT_F0;
          else if (state_q == ST_GOT_E0) state_d = ST_GOT_E0F0;
        end
        SC_BAT, SC_ERR, SC_OVR: begin
          arrow_d = '0;
`ifdef PS2_KEY_DECODER_WASD_EN
          wasd_d  = '0;
`endif
          silent  = 1'b1;
          state_d = ST_IDLE;
        end
        SC_ACK, SC_RESEND: state_d = state_q;
        default: begin
          state_d = ST_IDLE;
          case (state_q)
            ST_GOT_E0:   if (arw.hit) arrow_d[arw.id] = 1'b1;
            ST_GOT_E0F0: if (arw.hit) arrow_d[arw.id] = 1'b0;
`ifdef PS2_KEY_DECODER_WASD_EN
            ST_IDLE:     if (wsd.hit) wasd_d[wsd.id] = 1'b1;
            ST_GOT_F0:   if (wsd.hit) wasd_d[wsd.id] = 1'b0;
`endif
            default:     arrow_d = arrow_q;
          endcase
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

`ifdef PS2_KEY_DECODER_WASD_EN
    held_d = arrow_d | wasd_d;
`else
    held_d = arrow_d;
`endif

    // At most one direction can change per byte, so the lowest changed bit is the event key.
    chg       = held_d ^ held_cur;
    evt_d     = (|chg) & ~silent;
    id_d      = KEY_UP;
    for (int k = 3; k >= 0; k--) begin
      if (chg[k]) id_d = key_id_t'(k);
    end
    pressed_d = evt_d & held_d[id_d];
  end

  // ---- stage p1: registered state, held keys and event outputs ----
  always_ff @(posedge clk_100mHz or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      arrow_q    <= '0;
`ifdef PS2_KEY_DECODER_WASD_EN
      wasd_q     <= '0;
`endif
      evt_p1     <= 1'b0;
      id_p1      <= KEY_UP;
      pressed_p1 <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arrow_q    <= arrow_d;
`ifdef PS2_KEY_DECODER_WASD_EN
      wasd_q     <= wasd_d;
`endif
      evt_p1     <= evt_d;
      id_p1      <= id_d;
      pressed_p1 <= pressed_d;
    end
  end

  assign key_up      = held_cur[KEY_UP];
  assign key_down    = held_cur[KEY_DOWN];
  assign key_left    = held_cur[KEY_LEFT];
  assign key_right   = held_cur[KEY_RIGHT];
  assign key_event   = evt_p1;
  assign key_id      = id_p1;
  assign key_pressed = pressed_p1;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against a byte-level behavioural model.
// Build with PS2_KEY_DECODER_WASD_EN defined to also exercise the WASD mapping.
module tb_ps2_key_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       read_data;
  logic       key_up, key_down, key_left, key_right;
  logic       key_event, key_pressed;
  logic [1:0] key_id;

  always #5 clk = ~clk;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk_100mHz  (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .read_data   (read_data),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_event   (key_event),
    .key_id      (key_id),
    .key_pressed (key_pressed)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: held keys per source, pending prefix flags, cycle of last accepted byte.
  bit m_arrow [4];
  bit m_wasd  [4];
  bit m_ext, m_brk;
  int m_last;
  bit e_evt, e_pr;
  int e_id;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit held(input int k);
    return m_arrow[k] | m_wasd[k];
  endfunction

  function automatic int arrow_key(input logic [7:0] b);
    case (b)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int wasd_key(input logic [7:0] b);
    case (b)
      8'h1D: return 0;
      8'h1B: return 1;
      8'h1C: return 2;
      8'h23: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_arrow[k] = 1'b0;
      m_wasd[k]  = 1'b0;
    end
    m_ext = 1'b0; m_brk = 1'b0; m_last = cyc; e_evt = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit old [4];
    bit silent;
    int k;
    silent = 1'b0;
    for (int i = 0; i < 4; i++) old[i] = held(i);
    if ((m_ext || m_brk) && (cyc - m_last > T)) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end
    m_last = cyc;
    case (b)
      8'hE0: begin m_ext = 1'b1; m_brk = 1'b0; end
      8'hF0: m_brk = 1'b1;
      8'hAA, 8'hFF, 8'h00: begin
        for (int i = 0; i < 4; i++) begin m_arrow[i] = 1'b0; m_wasd[i] = 1'b0; end
        m_ext = 1'b0; m_brk = 1'b0; silent = 1'b1;
      end
      8'hFA, 8'hFE: ;
      default: begin
        if (m_ext) begin
          k = arrow_key(b);
          if (k >= 0) m_arrow[k] = !m_brk;
        end
`ifdef PS2_KEY_DECODER_WASD_EN
        else begin
          k = wasd_key(b);
          if (k >= 0) m_wasd[k] = !m_brk;
        end
`endif
        m_ext = 1'b0; m_brk = 1'b0;
      end
    endcase
    e_evt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (held(i) != old[i] && !silent) begin
        e_evt = 1'b1; e_id = i; e_pr = held(i);
      end
    end
  endtask

  task automatic check_all();
    check_eq("key_up",    key_up,    held(0));
    check_eq("key_down",  key_down,  held(1));
    check_eq("key_left",  key_left,  held(2));
    check_eq("key_right", key_right, held(3));
    check_eq("key_event", key_event, e_evt);
    if (e_evt) begin
      check_eq("key_id",      key_id,      e_id);
      check_eq("key_pressed", key_pressed, e_pr);
    end
  endtask

  // Called at a negedge; advances one clock and checks at the following negedge.
  task automatic tick_chk(input bit acc, input logic [7:0] b);
    @(posedge clk);
    cyc++;
    if (acc) model_byte(b);
    else     e_evt = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [7:0] b, input int idle_n);
    rx_data   = b;
    read_data = 1'b1;
    tick_chk(1'b1, b);
    read_data = 1'b0;
    rx_data   = 8'($urandom);
    repeat ((idle_n < 1) ? 1 : idle_n) tick_chk(1'b0, 8'h00);
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] codes [8];
    logic [7:0] misc  [7];
    int r;
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};
    misc  = '{8'hAA, 8'hFA, 8'hFE, 8'hFF, 8'h00, 8'h11, 8'h5A};
    r = $urandom_range(0, 99);
    if (r < 30)      return 8'hE0;
    else if (r < 47) return 8'hF0;
    else if (r < 92) return codes[$urandom_range(0, 7)];
    else             return misc[$urandom_range(0, 6)];
  endfunction

  initial begin
    reset = 1'b0; read_data = 1'b0; rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_up",    key_up,    1'b0);
    check_eq("rst_down",  key_down,  1'b0);
    check_eq("rst_left",  key_left,  1'b0);
    check_eq("rst_right", key_right, 1'b0);
    check_eq("rst_event", key_event, 1'b0);
    reset = 1'b1;
    tick_chk(1'b0, 8'h00);

    // Arrow make and break
    send(8'hE0, 2); send(8'h75, 2);
    check_eq("up_made", key_up, 1'b1);
    send(8'hE0, 2); send(8'hF0, 2); send(8'h75, 2);
    check_eq("up_broken", key_up, 1'b0);

    // Typematic repeats
    send(8'hE0, 1); send(8'h6B, 1);
    repeat (3) begin send(8'hE0, 1); send(8'h6B, 1); end
    check_eq("left_typematic", key_left, 1'b1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h6B, 1);

    // BAT clears silently; lone 75 is non-extended
    send(8'hE0, 2); send(8'h74, 2); send(8'hAA, 2); send(8'h75, 2);
    check_eq("bat_right", key_right, 1'b0);
    check_eq("bat_up",    key_up,    1'b0);

    // Prefix timeout and its boundary
    send(8'hE0, 16); send(8'h72, 2);
    check_eq("timeout_down", key_down, 1'b0);
    send(8'hE0, 14); send(8'h72, 2);
    check_eq("in_time_down", key_down, 1'b1);
    send(8'hE0, 1); send(8'hF0, 15); send(8'h72, 2);
    check_eq("edge_release", key_down, 1'b0);

    // Held-high strobe accepted once
    rx_data = 8'hE0; read_data = 1'b1;
    tick_chk(1'b1, 8'hE0);
    repeat (9) tick_chk(1'b0, 8'h00);
    read_data = 1'b0;
    tick_chk(1'b0, 8'h00);
    send(8'h72, 2);
    check_eq("held_strobe_down", key_down, 1'b1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h72, 2);

`ifdef PS2_KEY_DECODER_WASD_EN
    send(8'h1D, 2);
    check_eq("w_up", key_up, 1'b1);
    send(8'hE0, 1); send(8'h75, 2);
    send(8'hF0, 1); send(8'h1D, 2);
    check_eq("w_released_up_held", key_up, 1'b1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 2);
    check_eq("wasd_all_released", key_up, 1'b0);
`endif

    // Asynchronous reset mid-sequence
    send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_up",    key_up,    1'b0);
    check_eq("arst_event", key_event, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    send(8'hF0, 1); send(8'h75, 2);
    check_eq("orphan_break_up", key_up, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      send(pick_byte(), ($urandom_range(0, 9) == 0) ? $urandom_range(13, 19)
                                                    : $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
